// File: rtl/isqrt_arb_pkg.sv
// Shared widths, default sizing and tag-width helper for the isqrt arbiter slice.
package isqrt_arb_pkg;

    localparam int ISQRT_X_W           = 32;
    localparam int ISQRT_Y_W           = 16;
    localparam int N_REQ_DEF           = 3;
    localparam int MAX_OUTSTANDING_DEF = 16;

    function automatic int tag_w(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/isqrt_arb_tag_fifo.sv
// In-order FIFO of requester tags, one entry per request in flight through the isqrt.
module isqrt_arb_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head_tag,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_tag = mem[rd_ptr_reg];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/isqrt_arbiter.sv
// Shares one pipelined isqrt between N_REQ requesters and routes results back by tag.
// Define ISQRT_ARBITER_FIXED_PRIO_EN for lowest-index-wins priority instead of round robin.
module isqrt_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int N_REQ           = N_REQ_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ*ISQRT_X_W-1:0] req_x,
    output logic [N_REQ-1:0]           req_rdy,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [ISQRT_Y_W-1:0]       rsp_y,
    output logic                       isqrt_x_vld,
    output logic [ISQRT_X_W-1:0]       isqrt_x,
    input  logic                       isqrt_y_vld,
    input  logic [ISQRT_Y_W-1:0]       isqrt_y,
    output logic                       busy,
    output logic                       err
);

    localparam int TAG_W = tag_w(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ISQRT_X_W-1:0] req_x_arr [N_REQ];
    logic [TAG_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 accept;
    logic                 pop;
    logic [TAG_W-1:0]     head_tag;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_x_arr[gi] = req_x[gi*ISQRT_X_W +: ISQRT_X_W];
    end

`ifdef ISQRT_ARBITER_FIXED_PRIO_EN
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_vld[k]) begin
                grant_idx = TAG_W'(k);
                grant_any = 1'b1;
            end
        end
    end
`else
    logic [TAG_W-1:0] ptr_reg;
    logic [TAG_W-1:0] hi_idx;
    logic [TAG_W-1:0] lo_idx;
    logic             hi_any;
    logic             lo_any;

    // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_vld[k]) begin
                if (TAG_W'(k) > ptr_reg) begin
                    hi_any = 1'b1;
                    hi_idx = TAG_W'(k);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = TAG_W'(k);
                end
            end
        end
        grant_any = hi_any | lo_any;
        grant_idx = hi_any ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= TAG_W'(N_REQ - 1);
        end else if (accept) begin
            ptr_reg <= grant_idx;
        end
    end
`endif

    // Gated on the registered count only: a same-cycle pop never frees a slot early.
    assign accept  = grant_any & rst & ~fifo_full;
    assign req_rdy = accept ? (N_REQ'(1) << grant_idx) : '0;
    assign pop     = isqrt_y_vld & ~fifo_empty;
    assign busy    = (fifo_count != '0) | isqrt_x_vld;

    isqrt_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_tag (grant_idx),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            isqrt_x_vld <= 1'b0;
            isqrt_x     <= '0;
            rsp_vld     <= '0;
            rsp_y       <= '0;
            err         <= 1'b0;
        end else begin
            isqrt_x_vld <= accept;
            if (accept) begin
                isqrt_x <= req_x_arr[grant_idx];
            end
            rsp_vld <= pop ? (N_REQ'(1) << head_tag) : '0;
            if (pop) begin
                rsp_y <= isqrt_y;
            end
            if (isqrt_y_vld && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule
